regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of write-back requesters (0=ALU, 1=FPU, 2=MEM).
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-003 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  NREQ  per-requester write-back request valid.
REQ-005 SHALL have port req_fmode  input  NREQ  per-requester target file (1=float, 0=general).
REQ-006 SHALL have port req_reg  input  5*NREQ  per-requester destination register index (requester i in bits 5i+4:5i).
REQ-007 SHALL have port req_data  input  32*NREQ  per-requester write data (requester i in bits 32i+31:32i).
REQ-008 SHALL have port req_ready  output  NREQ  grant; a request transfers when req_valid[i] & req_ready[i].
REQ-009 SHALL have port wenable  output  1  registered write enable to register file.
REQ-010 SHALL have port wfmode  output  1  registered target file select.
REQ-011 SHALL have port wreg  output  5  registered destination index.
REQ-012 SHALL have port wdata  output  32  registered write data.
REQ-013 SHALL have port issue_valid  input  1  issue stage marks a destination as pending.
REQ-014 SHALL have port issue_fmode  input  1  file of the destination being marked.
REQ-015 SHALL have port issue_reg  input  5  index of the destination being marked.
REQ-016 SHALL have port q_fmode  input  2  file select for query ports 1 and 0.
REQ-017 SHALL have port q_reg  input  10  query indices (port 1 in bits 9:5, port 0 in bits 4:0).
REQ-018 SHALL have port q_busy  output  2  combinational: queried register has a pending write.

Function
REQ-019 SHALL grant at most one requester per cycle, round-robin: search starts at rr_ptr, ascending, wrapping at NREQ-1.
REQ-020 SHALL assert req_ready[i] combinationally only for the selected valid requester; no ready when no request is valid.
REQ-021 SHALL, on a transfer from i, set rr_ptr to (i+1) mod NREQ; rr_ptr SHALL be unchanged when nothing transfers.
REQ-022 SHALL register the transferred fmode/reg/data onto wfmode/wreg/wdata with wenable=1 the next cycle (1-cycle latency).
REQ-023 SHALL drive wenable=0 in any cycle following a cycle with no transfer; wfmode/wreg/wdata then hold their last values.
REQ-024 SHALL accept a transfer to general register 0 (ready asserted, rr_ptr advances) but drive wenable=0 for it.
REQ-025 SHALL keep a 64-bit scoreboard, one bit per general (bits 31:0) and float (bits 63:32) register.
REQ-026 SHALL set the scoreboard bit of (issue_fmode, issue_reg) on the clock edge when issue_valid=1.
REQ-027 SHALL clear the scoreboard bit of a transferred request's (fmode, reg) on the transfer edge.
REQ-028 SHALL let set win over clear when issue and transfer target the same bit in the same cycle.
REQ-029 SHALL never set the bit for general register 0; q_busy for general register 0 SHALL always read 0.
REQ-030 SHALL compute q_busy[k] = scoreboard bit of (q_fmode[k], q_reg[k]) from the registered scoreboard (no same-cycle bypass of issue or transfer).
REQ-031 SHALL accept transfers to registers whose scoreboard bit is clear without error; bit stays 0.

Reset
REQ-032 SHALL, while rstn=0 at a clock edge, set wenable=0, wfmode=0, wreg=0, wdata=0, rr_ptr=0, and scoreboard all zeros.
REQ-033 SHALL hold req_ready all zero while rstn=0; requests presented during reset are not transferred.
REQ-034 SHALL discard the scoreboard on reset mid-operation; the first post-reset cycle behaves as after power-up.

Verification
REQ-035 SHALL pass: all three valid every cycle after reset -> grants in order 0,1,2,0,... one per cycle; wenable=1 every cycle from the second.
REQ-036 SHALL pass: only req 1 valid, reg=7, fmode=1, data=32'hDEADBEEF -> next cycle wenable=1, wfmode=1, wreg=7, wdata=32'hDEADBEEF; rr_ptr=2.
REQ-037 SHALL pass: issue_valid with fmode=0, reg=5 -> q_busy=1 for (0,5) next cycle; after req 0 transfers (0,5) -> q_busy=0 the cycle after.
REQ-038 SHALL pass: issue (1,3) and transfer (1,3) in the same cycle -> bit for f3 remains 1.
REQ-039 SHALL pass: req 2 writes general reg 0 -> req_ready[2]=1, next cycle wenable=0; issue to general reg 0 -> q_busy stays 0.
REQ-040 SHALL pass: rstn=0 for one cycle with scoreboard bits set and requests valid -> req_ready=0, then wenable=0, q_busy=0, rr_ptr=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the general/float register files.
// It round-robins the writers and tracks pending destinations in a scoreboard.
module regfile_wb_arbiter #(
    parameter int NREQ = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_fmode,
    input  logic [5*NREQ-1:0]    req_reg,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wenable,
    output logic                 wfmode,
    output logic [4:0]           wreg,
    output logic [31:0]          wdata,
    input  logic                 issue_valid,
    input  logic                 issue_fmode,
    input  logic [4:0]           issue_reg,
    input  logic [1:0]           q_fmode,
    input  logic [9:0]           q_reg,
    output logic [1:0]           q_busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gidx;
    logic          found;
    logic          xfer;
    logic          sel_fmode;
    logic [4:0]    sel_reg;
    logic [31:0]   sel_data;
    logic [63:0]   sb;
    logic [63:0]   sb_next;
    int            idx;

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = PW'(idx);
            end
        end
    end

    assign xfer      = found && rstn;
    assign sel_fmode = req_fmode[gidx];
    assign sel_reg   = req_reg[int'(gidx)*5 +: 5];
    assign sel_data  = req_data[int'(gidx)*32 +: 32];

    always_comb begin
        req_ready = '0;
        if (xfer)
            req_ready[gidx] = 1'b1;
    end

    // Issue is applied after the clear so a same-cycle set wins.
    always_comb begin
        sb_next = sb;
        if (xfer)
            sb_next[{sel_fmode, sel_reg}] = 1'b0;
        if (issue_valid && (issue_fmode || issue_reg != 5'd0))
            sb_next[{issue_fmode, issue_reg}] = 1'b1;
    end

    always_comb begin
        q_busy = '0;
        for (int k = 0; k < 2; k++)
            q_busy[k] = sb[{q_fmode[k], q_reg[k*5 +: 5]}];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wenable <= 1'b0;
            wfmode  <= 1'b0;
            wreg    <= '0;
            wdata   <= '0;
            rr_ptr  <= '0;
            sb      <= '0;
        end else begin
            wenable <= xfer && (sel_fmode || sel_reg != 5'd0);
            sb      <= sb_next;
            if (xfer) begin
                wfmode <= sel_fmode;
                wreg   <= sel_reg;
                wdata  <= sel_data;
                rr_ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
// A reference model queues each expected write-back and checks it a cycle later.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_fmode;
    logic [5*NREQ-1:0] req_reg;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              wenable;
    logic              wfmode;
    logic [4:0]        wreg;
    logic [31:0]       wdata;
    logic              issue_valid;
    logic              issue_fmode;
    logic [4:0]        issue_reg;
    logic [1:0]        q_fmode;
    logic [9:0]        q_reg;
    logic [1:0]        q_busy;

    typedef struct packed {
        logic        en;
        logic        fm;
        logic [4:0]  r;
        logic [31:0] d;
    } wb_t;

    wb_t         expq[$];
    wb_t         mlast;
    logic [63:0] msb;
    int          mptr;
    int          errors = 0;
    int          checks = 0;

    regfile_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_fmode(req_fmode),
        .req_reg(req_reg), .req_data(req_data),
        .req_ready(req_ready),
        .wenable(wenable), .wfmode(wfmode),
        .wreg(wreg), .wdata(wdata),
        .issue_valid(issue_valid), .issue_fmode(issue_fmode),
        .issue_reg(issue_reg),
        .q_fmode(q_fmode), .q_reg(q_reg), .q_busy(q_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setreq(int i, logic v, logic fm, logic [4:0] r,
                          logic [31:0] d);
        req_valid[i]         = v;
        req_fmode[i]         = fm;
        req_reg[i*5 +: 5]    = r;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic setq(int k, logic fm, logic [4:0] r);
        q_fmode[k]       = fm;
        q_reg[k*5 +: 5]  = r;
    endtask

    // One clock: check comb outputs mid-cycle, then the registered write-back.
    task automatic step();
        int              g;
        logic [NREQ-1:0] er;
        wb_t             e;
        @(negedge clk);
        g = -1;
        if (rstn)
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (mptr + k) % NREQ;
                if (g < 0 && req_valid[i])
                    g = i;
            end
        er = '0;
        if (g >= 0)
            er[g] = 1'b1;
        chk("ready", 64'(req_ready), 64'(er));
        for (int k = 0; k < 2; k++)
            chk($sformatf("busy%0d", k), 64'(q_busy[k]),
                64'(msb[{q_fmode[k], q_reg[k*5 +: 5]}]));
        if (!rstn) begin
            mlast = '0;
            msb   = '0;
            mptr  = 0;
        end else begin
            if (g >= 0) begin
                mlast.fm = req_fmode[g];
                mlast.r  = req_reg[g*5 +: 5];
                mlast.d  = req_data[g*32 +: 32];
                mlast.en = mlast.fm || mlast.r != 5'd0;
                msb[{mlast.fm, mlast.r}] = 1'b0;
                mptr = (g + 1) % NREQ;
            end else begin
                mlast.en = 1'b0;
            end
            if (issue_valid && (issue_fmode || issue_reg != 5'd0))
                msb[{issue_fmode, issue_reg}] = 1'b1;
        end
        expq.push_back(mlast);
        @(posedge clk);
        #1;
        e = expq.pop_front();
        chk("wb", 64'({wenable, wfmode, wreg, wdata}), 64'(e));
    endtask

    initial begin
        rstn        = 1'b0;
        req_valid   = '0;
        req_fmode   = '0;
        req_reg     = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_fmode = 1'b0;
        issue_reg   = '0;
        q_fmode     = '0;
        q_reg       = '0;
        msb         = '0;
        mptr        = 0;
        mlast       = '0;
        @(posedge clk);
        #1;

        // Reset state with requests pending: nothing may transfer.
        setreq(0, 1, 0, 5'd1, 32'h11);
        setreq(1, 1, 1, 5'd2, 32'h22);
        setreq(2, 1, 0, 5'd3, 32'h33);
        step();
        rstn = 1'b1;

        // All three valid: strict rotation 0,1,2,0,1,2.
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NREQ; i++)
                setreq(i, 1, i[0], 5'(4 + i + n), 32'hA000_0000 + 32'(n * 16 + i));
            step();
        end

        // Lone requester 1, then everyone: pointer must have moved to 2.
        req_valid = '0;
        setreq(1, 1, 1, 5'd7, 32'hDEADBEEF);
        step();
        req_valid = '1;
        step();
        req_valid = '0;

        // Issue g5, see it busy, retire it through requester 0.
        issue_valid = 1;
        issue_fmode = 0;
        issue_reg   = 5'd5;
        setq(0, 0, 5'd5);
        setq(1, 1, 5'd3);
        step();
        issue_valid = 0;
        setreq(0, 1, 0, 5'd5, 32'h5555_0005);
        step();
        req_valid = '0;
        step();

        // Issue and retire f3 in the same cycle: set wins.
        issue_valid = 1;
        issue_fmode = 1;
        issue_reg   = 5'd3;
        step();
        setreq(2, 1, 1, 5'd3, 32'h0F0F_0003);
        step();
        issue_valid = 0;
        req_valid   = '0;
        step();

        // Writes and issues to g0 are swallowed.
        setreq(2, 1, 0, 5'd0, 32'hFFFF_FFFF);
        issue_valid = 1;
        issue_fmode = 0;
        issue_reg   = 5'd0;
        setq(0, 0, 5'd0);
        step();
        issue_valid = 0;
        req_valid   = '0;
        step();

        // Retire a register that was never busy.
        setreq(1, 1, 0, 5'd9, 32'h0000_0909);
        setq(1, 0, 5'd9);
        step();
        req_valid = '0;
        step();

        // Build state, then reset mid-flight.
        issue_valid = 1;
        issue_fmode = 1;
        issue_reg   = 5'd12;
        setq(0, 1, 5'd12);
        setreq(0, 1, 1, 5'd20, 32'h2020_2020);
        step();
        issue_valid = 0;
        req_valid   = '1;
        rstn        = 1'b0;
        step();
        rstn = 1'b1;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
